// File: rtl/cellram_pkg.sv
// Shared types and widths for the cell RAM arbiter: FSM encoding, bus widths
// and a width helper that never returns zero.
package cellram_pkg;

    localparam int MEM_ADDR_W = 23;
    localparam int MEM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin picker: scans from the port after i_last and
// returns the first requesting port as one-hot and as an index.
module rr_priority_select #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_last,
    output logic [NUM_PORTS-1:0] o_grant,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_valid
);

    int               v_pos;
    logic [IDX_W-1:0] v_idx;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        v_pos   = 0;
        v_idx   = '0;
        // i_last itself is visited last, so a lone requester is still found.
        for (int k = 1; k <= NUM_PORTS; k++) begin
            v_pos = int'(i_last) + k;
            if (v_pos >= NUM_PORTS) begin
                v_pos = v_pos - NUM_PORTS;
            end
            v_idx = IDX_W'(v_pos);
            if (!o_valid && i_req[v_idx]) begin
                o_valid        = 1'b1;
                o_grant[v_idx] = 1'b1;
                o_idx          = v_idx;
            end
        end
    end

endmodule

// File: rtl/cellram_arbiter.sv
// Round-robin arbiter and asynchronous-mode access sequencer for the shared
// 16-bit cell RAM: IDLE -> SETUP -> ACCESS (ACCESS_CYCLES) -> HOLD -> IDLE.
module cellram_arbiter
    import cellram_pkg::*;
#(
    parameter int NUM_PORTS     = 4,
    parameter int ACCESS_CYCLES = 7
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             req,
    input  logic [NUM_PORTS-1:0]             we,
    input  logic [NUM_PORTS*MEM_ADDR_W-1:0]  addr,
    input  logic [NUM_PORTS*MEM_DATA_W-1:0]  wdata,
    output logic [NUM_PORTS-1:0]             ack,
    output logic [MEM_DATA_W-1:0]            rdata,
    output logic [MEM_ADDR_W-1:0]            mem_addr,
    input  logic [MEM_DATA_W-1:0]            mem_data_in,
    output logic [MEM_DATA_W-1:0]            mem_data_out,
    output logic                             mem_data_drive,
    output logic                             mem_oe,
    output logic                             mem_we,
    output logic                             mem_addr_valid,
    output logic                             mem_clk
);

    localparam int IDX_W = idx_width(NUM_PORTS);
    localparam int CNT_W = idx_width(ACCESS_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    state_e                  r_state;
    state_e                  w_next;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_last;
    logic [IDX_W-1:0]        r_sel;
    logic                    r_we;
    logic [MEM_ADDR_W-1:0]   r_addr;
    logic [MEM_DATA_W-1:0]   r_wdata;
    logic [MEM_DATA_W-1:0]   r_rdata;

    logic [NUM_PORTS-1:0]    w_gnt_onehot;
    logic [IDX_W-1:0]        w_gnt_idx;
    logic                    w_gnt_valid;
    logic                    w_cap_we;
    logic [MEM_ADDR_W-1:0]   w_cap_addr;
    logic [MEM_DATA_W-1:0]   w_cap_wdata;
    logic [NUM_PORTS-1:0]    w_sel_onehot;
    logic                    w_access_done;

    rr_priority_select #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr (
        .i_req   (req),
        .i_last  (r_last),
        .o_grant (w_gnt_onehot),
        .o_idx   (w_gnt_idx),
        .o_valid (w_gnt_valid)
    );

    always_comb begin
        w_cap_we    = 1'b0;
        w_cap_addr  = '0;
        w_cap_wdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_gnt_onehot[p]) begin
                w_cap_we    = we[p];
                w_cap_addr  = addr[p*MEM_ADDR_W +: MEM_ADDR_W];
                w_cap_wdata = wdata[p*MEM_DATA_W +: MEM_DATA_W];
            end
        end
    end

    always_comb begin
        w_sel_onehot = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_sel_onehot[p] = (r_sel == IDX_W'(p));
        end
    end

    assign w_access_done = (r_state == ACCESS) && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_gnt_valid) w_next = SETUP;
            SETUP:   w_next = ACCESS;
            ACCESS:  if (r_cnt == '0) w_next = HOLD;
            HOLD:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Handshake: a requester holds req/we/addr/wdata until it samples ack
    // (one-cycle pulse in HOLD); req is only looked at in IDLE, so dropping it
    // mid-access never aborts, and req still high in the following IDLE is a
    // fresh request. r_last starts at the top port so port 0 wins first.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_last  <= IDX_W'(NUM_PORTS - 1);
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == IDLE && w_gnt_valid) begin
                r_sel   <= w_gnt_idx;
                r_last  <= w_gnt_idx;
                r_we    <= w_cap_we;
                r_addr  <= w_cap_addr;
                r_wdata <= w_cap_wdata;
            end
            if (r_state == SETUP) begin
                r_cnt <= CNT_LOAD;
            end else if (r_state == ACCESS && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_access_done && !r_we) begin
                r_rdata <= mem_data_in;
            end
        end
    end

    always_comb begin
        mem_oe         = 1'b1;
        mem_we         = 1'b1;
        mem_addr_valid = 1'b1;
        mem_data_drive = 1'b0;
        ack            = '0;
        case (r_state)
            SETUP: begin
                mem_addr_valid = 1'b0;
                mem_data_drive = r_we;
            end
            ACCESS: begin
                mem_addr_valid = 1'b0;
                mem_data_drive = r_we;
                mem_oe         = r_we;
                mem_we         = !r_we;
            end
            HOLD: begin
                mem_data_drive = r_we;
                ack            = w_sel_onehot;
            end
            default: ;
        endcase
    end

    assign mem_addr     = r_addr;
    assign mem_data_out = r_wdata;
    assign rdata        = r_rdata;
    assign mem_clk      = 1'b0;

endmodule

// File: tb/tb_cellram_arbiter.sv
// Bench for cellram_arbiter: timeline model of each access compared every
// cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_cellram_arbiter;

    localparam int N  = 4;
    localparam int AC = 7;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N-1:0]      we = '0;
    logic [N*23-1:0]   addr = '0;
    logic [N*16-1:0]   wdata = '0;
    logic [N-1:0]      ack;
    logic [15:0]       rdata;
    logic [22:0]       mem_addr;
    logic [15:0]       mem_data_in = 16'hDEAD;
    logic [15:0]       mem_data_out;
    logic              mem_data_drive;
    logic              mem_oe;
    logic              mem_we;
    logic              mem_addr_valid;
    logic              mem_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    cellram_arbiter #(
        .NUM_PORTS     (N),
        .ACCESS_CYCLES (AC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .we             (we),
        .addr           (addr),
        .wdata          (wdata),
        .ack            (ack),
        .rdata          (rdata),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .mem_data_drive (mem_data_drive),
        .mem_oe         (mem_oe),
        .mem_we         (mem_we),
        .mem_addr_valid (mem_addr_valid),
        .mem_clk        (mem_clk)
    );

    // ---------------- clock / reset / watchdog ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- RAM model on the pins ----------------
    logic [15:0] ram_mem [int];
    logic [15:0] m_mem   [int];

    function automatic logic [15:0] ram_rd(input int a);
        return ram_mem.exists(a) ? ram_mem[a] : 16'h0000;
    endfunction

    function automatic logic [15:0] model_rd(input int a);
        return m_mem.exists(a) ? m_mem[a] : 16'h0000;
    endfunction

    always @(negedge clk) begin
        if (!mem_we && mem_data_drive) ram_mem[int'(mem_addr)] = mem_data_out;
        mem_data_in <= !mem_oe ? ram_rd(int'(mem_addr)) : 16'hDEAD;
    end

    // ---------------- behavioural model ----------------
    // m_phase counts edges since capture: 1 = address setup, 2..AC+1 = strobe
    // active, AC+2 = ack cycle, 0 = free to arbitrate.
    int          m_phase = 0;
    int          m_win = 0;
    int          m_last = N - 1;
    int          m_p;
    logic        m_we = 1'b0;
    logic [22:0] m_addr = '0;
    logic [15:0] m_wdata = '0;
    logic [15:0] m_rdata = '0;

    always @(posedge clk) begin
        if (!reset) begin
            m_phase = 0; m_win = 0; m_last = N - 1;
            m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        end else if (m_phase == 0) begin
            for (int k = 1; k <= N; k++) begin
                m_p = (m_last + k) % N;
                if (m_phase == 0 && req[m_p]) begin
                    m_win = m_p; m_last = m_p; m_we = we[m_p];
                    m_addr = addr[m_p*23 +: 23]; m_wdata = wdata[m_p*16 +: 16];
                    m_phase = 1;
                end
            end
        end else if (m_phase == AC + 1) begin
            if (!m_we) m_rdata = model_rd(int'(m_addr));
            m_phase = m_phase + 1;
        end else if (m_phase == AC + 2) begin
            if (m_we) m_mem[int'(m_addr)] = m_wdata;
            m_phase = 0;
        end else begin
            m_phase = m_phase + 1;
        end
    end

    // ---------------- compare process and logging ----------------
    int          ack_port_q[$];
    int          ack_cyc_q[$];
    logic [15:0] ack_rd_q[$];
    logic [N-1:0] ack_vec_q[$];
    int oe_low_cnt = 0, we_low_cnt = 0, drv_cnt = 0;
    bit in_act, in_acc;

    always @(negedge clk) begin
        if (chk_en) begin
            in_act = (m_phase >= 1 && m_phase <= AC + 1);
            in_acc = (m_phase >= 2 && m_phase <= AC + 1);
            check("mem_oe", mem_oe, !(in_acc && !m_we));
            check("mem_we", mem_we, !(in_acc && m_we));
            check("mem_addr_valid", mem_addr_valid, !in_act);
            check("mem_data_drive", mem_data_drive, (m_phase >= 1 && m_phase <= AC + 2) && m_we);
            check("ack", ack, (m_phase == AC + 2) ? (N'(1) << m_win) : N'(0));
            check("rdata", rdata, m_rdata);
            check("mem_addr", mem_addr, m_addr);
            check("mem_data_out", mem_data_out, m_wdata);
            check("mem_clk_low", mem_clk, 1'b0);
            check("oe_we_overlap", !mem_oe && !mem_we, 1'b0);
            check("drive_during_oe", !mem_oe && mem_data_drive, 1'b0);
            check("ack_onehot0", $onehot0(ack), 1'b1);
        end
        if (ack != '0) begin
            for (int p = 0; p < N; p++) if (ack[p]) ack_port_q.push_back(p);
            ack_cyc_q.push_back(cyc);
            ack_rd_q.push_back(rdata);
            ack_vec_q.push_back(ack);
        end
        if (!mem_oe) oe_low_cnt++;
        if (!mem_we) we_low_cnt++;
        if (mem_data_drive) drv_cnt++;
    end

    function automatic int port_at(input int i);
        return (i < ack_port_q.size()) ? ack_port_q[i] : -1;
    endfunction
    function automatic int cyc_at(input int i);
        return (i < ack_cyc_q.size()) ? ack_cyc_q[i] : -1000;
    endfunction
    function automatic logic [15:0] rd_at(input int i);
        return (i < ack_rd_q.size()) ? ack_rd_q[i] : 16'hxxxx;
    endfunction
    function automatic logic [N-1:0] vec_at(input int i);
        return (i < ack_vec_q.size()) ? ack_vec_q[i] : 'x;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        ack_port_q.delete(); ack_cyc_q.delete(); ack_rd_q.delete(); ack_vec_q.delete();
        oe_low_cnt = 0; we_low_cnt = 0; drv_cnt = 0;
    endtask

    task automatic set_port(input int p, input logic w, input logic [22:0] a, input logic [15:0] d);
        we[p] = w;
        addr[p*23 +: 23] = a;
        wdata[p*16 +: 16] = d;
    endtask

    task automatic preload(input int a, input logic [15:0] d);
        ram_mem[a] = d;
        m_mem[a] = d;
    endtask

    task automatic wait_acks(input string name, input int n, input int budget, input bit drop_each);
        int b;
        b = 0;
        while (ack_port_q.size() < n && b < budget) begin
            tick(1);
            b++;
            if (drop_each && ack != '0) req = req & ~ack;
        end
        check({name, "_acks_within_budget"}, ack_port_q.size() >= n, 1'b1);
    endtask

    int cap;
    int exp_q[$];

    initial begin
        // reset values
        reset = 1'b0;
        tick(1);
        chk_en = 1'b1;
        tick(2);
        check("rst_ack", ack, 4'b0000);
        check("rst_rdata", rdata, 16'h0000);
        check("rst_mem_addr", mem_addr, 23'h0);
        check("rst_mem_data_out", mem_data_out, 16'h0000);
        check("rst_drive", mem_data_drive, 1'b0);
        check("rst_strobes", {mem_oe, mem_we, mem_addr_valid}, 3'b111);
        reset = 1'b1;
        tick(2);

        // single read: port 2, 0x12345 -> 0xBEEF
        preload(int'(23'h12345), 16'hBEEF);
        clear_logs();
        set_port(2, 1'b0, 23'h12345, 16'h0000);
        req[2] = 1'b1;
        cap = cyc + 1;
        wait_acks("rd", 1, 40, 1'b1);
        tick(3);
        check("rd_ack_vec", vec_at(0), 4'b0100);
        check("rd_ack_latency", cyc_at(0) - cap, 8);
        check("rd_rdata", rd_at(0), 16'hBEEF);
        check("rd_oe_low_cycles", oe_low_cnt, 7);
        check("rd_we_low_cycles", we_low_cnt, 0);
        check("rd_drive_cycles", drv_cnt, 0);

        // single write: port 0, 0xA5A5 -> 0x7FFFFF
        clear_logs();
        set_port(0, 1'b1, 23'h7FFFFF, 16'hA5A5);
        req[0] = 1'b1;
        cap = cyc + 1;
        wait_acks("wr", 1, 40, 1'b1);
        tick(3);
        check("wr_ack_vec", vec_at(0), 4'b0001);
        check("wr_ack_latency", cyc_at(0) - cap, 8);
        check("wr_we_low_cycles", we_low_cnt, 7);
        check("wr_oe_low_cycles", oe_low_cnt, 0);
        check("wr_drive_cycles", drv_cnt, 9);
        check("wr_ram_content", ram_rd(int'(23'h7FFFFF)), 16'hA5A5);
        check("wr_rdata_unchanged", rdata, 16'hBEEF);

        // fairness: all four ports continuously, after a reset
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        preload(int'(23'h2000), 16'h2222);
        preload(int'(23'h4000), 16'h4444);
        set_port(0, 1'b1, 23'h1000, 16'h1111);
        set_port(1, 1'b0, 23'h2000, 16'h0000);
        set_port(2, 1'b1, 23'h3000, 16'h3333);
        set_port(3, 1'b0, 23'h4000, 16'h0000);
        clear_logs();
        req = 4'b1111;
        wait_acks("rr", 8, 150, 1'b0);
        req = 4'b0000;
        tick(3);
        exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int i = 0; i < 8; i++) check("rr_order", port_at(i), exp_q[i]);
        for (int i = 1; i < 8; i++) check("rr_period", cyc_at(i) - cyc_at(i - 1), 10);
        check("rr_rdata_p1", rd_at(1), 16'h2222);
        check("rr_rdata_p3", rd_at(3), 16'h4444);
        check("rr_ram_p0", ram_rd(int'(23'h1000)), 16'h1111);
        check("rr_ram_p2", ram_rd(int'(23'h3000)), 16'h3333);

        // reset during the third ACCESS cycle of a write
        preload(int'(23'h0100), 16'h1234);
        clear_logs();
        set_port(2, 1'b1, 23'h0200, 16'h7777);
        req[2] = 1'b1;
        cap = cyc + 1;
        for (int g = 0; g < 20 && cyc < cap + 3; g++) tick(1);
        check("mid_we_active", mem_we, 1'b0);
        set_port(0, 1'b0, 23'h0100, 16'h0000);
        req[0] = 1'b1;
        reset = 1'b0;
        tick(1);
        check("mid_rst_we", mem_we, 1'b1);
        check("mid_rst_addr_valid", mem_addr_valid, 1'b1);
        check("mid_rst_drive", mem_data_drive, 1'b0);
        check("mid_rst_ack", ack, 4'b0000);
        reset = 1'b1;
        clear_logs();
        wait_acks("mid", 2, 60, 1'b1);
        tick(3);
        check("mid_first_grant", port_at(0), 0);
        check("mid_second_grant", port_at(1), 2);
        check("mid_rdata_p0", rd_at(0), 16'h1234);
        check("mid_ram_p2", ram_rd(int'(23'h0200)), 16'h7777);

        // port 1 drops req during SETUP
        preload(int'(23'h0300), 16'h5A5A);
        clear_logs();
        set_port(1, 1'b0, 23'h0300, 16'h0000);
        req[1] = 1'b1;
        cap = cyc + 1;
        tick(1);
        req[1] = 1'b0;
        wait_acks("drop", 1, 40, 1'b0);
        tick(20);
        check("drop_ack_count", ack_port_q.size(), 1);
        check("drop_ack_vec", vec_at(0), 4'b0010);
        check("drop_ack_latency", cyc_at(0) - cap, 8);
        check("drop_rdata", rd_at(0), 16'h5A5A);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
